// File: rtl/id_ex_reg_pkg.sv
// ID/EX pipeline register shared types.
// Field widths, ALU op encodings and the bubble control word.
package id_ex_reg_pkg;

  localparam int XLEN         = 32;
  localparam int REG_IDX      = 5;
  localparam int ALU_OP_W     = 4;
  localparam int MEM_TO_REG_W = 2;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10,
    ALU_PASS = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic [ALU_OP_W-1:0]     alu_op;
    logic                    alu_src;
    logic                    mem_read;
    logic                    mem_write;
    logic                    reg_write;
    logic [MEM_TO_REG_W-1:0] mem_to_reg;
    logic                    branch;
    logic                    jump;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    imm;
    logic [REG_IDX-1:0] rs1;
    logic [REG_IDX-1:0] rs2;
    logic [REG_IDX-1:0] rd;
  } id_ex_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic logic wb_hit(
    input logic               we,
    input logic [REG_IDX-1:0] wrd,
    input logic [REG_IDX-1:0] rs
  );
    return we && (wrd != '0) && (wrd == rs);
  endfunction

endpackage

// File: rtl/id_ex_reg_opnd_cap.sv
// One EX operand register with write-back bypass at load
// and write-back refresh while the held instruction stalls.
module opnd_cap
  import id_ex_reg_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               stall,
  input  logic               id_valid,
  input  logic [REG_IDX-1:0] id_rs,
  input  logic [XLEN-1:0]    id_data,
  input  logic               ex_valid,
  input  logic [REG_IDX-1:0] ex_rs,
  input  logic               wb_reg_write,
  input  logic [REG_IDX-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  output logic [XLEN-1:0]    data
);

  logic ld_hit;
  logic st_hit;

  assign ld_hit = wb_hit(wb_reg_write, wb_rd, id_rs);
  assign st_hit = ex_valid && wb_hit(wb_reg_write, wb_rd, ex_rs);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
    end else if (flush) begin
      data <= '0;
    end else if (stall) begin
      if (st_hit) data <= wb_data;
    end else if (!id_valid) begin
      data <= '0;
    end else begin
      data <= ld_hit ? wb_data : id_data;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: load, stall-hold, flush-to-bubble,
// with operand capture delegated to two opnd_cap instances.
module id_ex_reg
  import id_ex_reg_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    id_valid,
  input  logic [XLEN-1:0]         id_pc,
  input  logic [XLEN-1:0]         id_rs1_data,
  input  logic [XLEN-1:0]         id_rs2_data,
  input  logic [XLEN-1:0]         id_imm,
  input  logic [REG_IDX-1:0]      id_rs1,
  input  logic [REG_IDX-1:0]      id_rs2,
  input  logic [REG_IDX-1:0]      id_rd,
  input  logic [ALU_OP_W-1:0]     id_alu_op,
  input  logic                    id_alu_src,
  input  logic                    id_mem_read,
  input  logic                    id_mem_write,
  input  logic                    id_reg_write,
  input  logic [MEM_TO_REG_W-1:0] id_mem_to_reg,
  input  logic                    id_branch,
  input  logic                    id_jump,
  input  logic                    wb_reg_write,
  input  logic [REG_IDX-1:0]      wb_rd,
  input  logic [XLEN-1:0]         wb_data,
  output logic                    ex_valid,
  output logic [XLEN-1:0]         ex_pc,
  output logic [XLEN-1:0]         ex_rs1_data,
  output logic [XLEN-1:0]         ex_rs2_data,
  output logic [XLEN-1:0]         ex_imm,
  output logic [REG_IDX-1:0]      ex_rs1,
  output logic [REG_IDX-1:0]      ex_rs2,
  output logic [REG_IDX-1:0]      ex_rd,
  output logic [ALU_OP_W-1:0]     ex_alu_op,
  output logic                    ex_alu_src,
  output logic                    ex_mem_read,
  output logic                    ex_mem_write,
  output logic                    ex_reg_write,
  output logic [MEM_TO_REG_W-1:0] ex_mem_to_reg,
  output logic                    ex_branch,
  output logic                    ex_jump
);

  logic   valid_q;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_d;
  id_ex_t pay_q;
  id_ex_t pay_d;

  assign ctrl_d = '{
    alu_op:     id_alu_op,
    alu_src:    id_alu_src,
    mem_read:   id_mem_read,
    mem_write:  id_mem_write,
    reg_write:  id_reg_write,
    mem_to_reg: id_mem_to_reg,
    branch:     id_branch,
    jump:       id_jump
  };

  assign pay_d = '{
    pc:  id_pc,
    imm: id_imm,
    rs1: id_rs1,
    rs2: id_rs2,
    rd:  id_rd
  };

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_BUBBLE;
      pay_q   <= '0;
    end else if (flush || (!stall && !id_valid)) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_BUBBLE;
      pay_q   <= '0;
    end else if (!stall) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_d;
      pay_q   <= pay_d;
    end
  end

  opnd_cap u_rs1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .stall        (stall),
    .id_valid     (id_valid),
    .id_rs        (id_rs1),
    .id_data      (id_rs1_data),
    .ex_valid     (valid_q),
    .ex_rs        (pay_q.rs1),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .data         (ex_rs1_data)
  );

  opnd_cap u_rs2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .stall        (stall),
    .id_valid     (id_valid),
    .id_rs        (id_rs2),
    .id_data      (id_rs2_data),
    .ex_valid     (valid_q),
    .ex_rs        (pay_q.rs2),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .data         (ex_rs2_data)
  );

  assign ex_valid      = valid_q;
  assign ex_pc         = pay_q.pc;
  assign ex_imm        = pay_q.imm;
  assign ex_rs1        = pay_q.rs1;
  assign ex_rs2        = pay_q.rs2;
  assign ex_rd         = pay_q.rd;
  assign ex_alu_op     = ctrl_q.alu_op;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_branch     = ctrl_q.branch;
  assign ex_jump       = ctrl_q.jump;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed and random checks of id_ex_reg against
// a rule-level model of the EX register contents.
module tb_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic        branch;
    logic        jump;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  rec_t        id;
  rec_t        dut;
  rec_t        m;
  rec_t        exp_v;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_reg u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .id_valid      (id.valid),
    .id_pc         (id.pc),
    .id_rs1_data   (id.rs1_data),
    .id_rs2_data   (id.rs2_data),
    .id_imm        (id.imm),
    .id_rs1        (id.rs1),
    .id_rs2        (id.rs2),
    .id_rd         (id.rd),
    .id_alu_op     (id.alu_op),
    .id_alu_src    (id.alu_src),
    .id_mem_read   (id.mem_read),
    .id_mem_write  (id.mem_write),
    .id_reg_write  (id.reg_write),
    .id_mem_to_reg (id.mem_to_reg),
    .id_branch     (id.branch),
    .id_jump       (id.jump),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .ex_valid      (dut.valid),
    .ex_pc         (dut.pc),
    .ex_rs1_data   (dut.rs1_data),
    .ex_rs2_data   (dut.rs2_data),
    .ex_imm        (dut.imm),
    .ex_rs1        (dut.rs1),
    .ex_rs2        (dut.rs2),
    .ex_rd         (dut.rd),
    .ex_alu_op     (dut.alu_op),
    .ex_alu_src    (dut.alu_src),
    .ex_mem_read   (dut.mem_read),
    .ex_mem_write  (dut.mem_write),
    .ex_reg_write  (dut.reg_write),
    .ex_mem_to_reg (dut.mem_to_reg),
    .ex_branch     (dut.branch),
    .ex_jump       (dut.jump)
  );

  // What the EX register should hold after one edge.
  function automatic rec_t model(rec_t cur, rec_t in);
    rec_t r;
    bit   hit1, hit2;
    if (!rst_n || flush) return '0;
    if (stall) begin
      r = cur;
      if (cur.valid && wb_reg_write && wb_rd != 0) begin
        if (wb_rd == cur.rs1) r.rs1_data = wb_data;
        if (wb_rd == cur.rs2) r.rs2_data = wb_data;
      end
      return r;
    end
    if (!in.valid) return '0;
    r = in;
    hit1 = wb_reg_write && wb_rd != 0 && wb_rd == in.rs1;
    hit2 = wb_reg_write && wb_rd != 0 && wb_rd == in.rs2;
    if (hit1) r.rs1_data = wb_data;
    if (hit2) r.rs2_data = wb_data;
    return r;
  endfunction

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(string tag);
    rec_t nxt;
    nxt = model(m, id);
    @(posedge clk);
    #1;
    m = nxt;
    chk(tag, 256'(dut), 256'(m));
  endtask

  function automatic rec_t rnd_id();
    rec_t r;
    r.valid      = ($urandom_range(0, 4) != 0);
    r.pc         = $urandom;
    r.rs1_data   = $urandom;
    r.rs2_data   = $urandom;
    r.imm        = $urandom;
    r.rs1        = 5'($urandom_range(0, 3));
    r.rs2        = 5'($urandom_range(0, 3));
    r.rd         = 5'($urandom);
    r.alu_op     = 4'($urandom);
    r.alu_src    = 1'($urandom);
    r.mem_read   = 1'($urandom);
    r.mem_write  = 1'($urandom);
    r.reg_write  = 1'($urandom);
    r.mem_to_reg = 2'($urandom);
    r.branch     = 1'($urandom);
    r.jump       = 1'($urandom);
    return r;
  endfunction

  initial begin
    m = '0;
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    wb_reg_write = 1'b0;
    wb_rd = '0;
    wb_data = '0;
    id = rnd_id();
    id.valid = 1'b1;
    stall = 1'b1;
    step("reset_full");
    chk("reset_valid", 256'(dut.valid), 256'(0));

    rst_n = 1'b1;
    stall = 1'b0;
    id = rnd_id();
    id.valid = 1'b1;
    id.pc = 32'h100;
    id.rs1 = 5'd3;
    id.rs1_data = 32'hA;
    id.reg_write = 1'b1;
    id.mem_write = 1'b1;
    step("load_full");
    chk("load_pc", 256'(dut.pc), 256'(32'h100));
    chk("load_rs1", 256'(dut.rs1_data), 256'(32'hA));
    chk("load_valid", 256'(dut.valid), 256'(1));

    stall = 1'b1;
    flush = 1'b1;
    id = rnd_id();
    step("flush_stall_full");
    chk("flush_valid", 256'(dut.valid), 256'(0));
    chk("flush_rw", 256'(dut.reg_write), 256'(0));
    chk("flush_mw", 256'(dut.mem_write), 256'(0));

    stall = 1'b0;
    flush = 1'b0;
    id = rnd_id();
    id.valid = 1'b1;
    id.rs1 = 5'd5;
    id.rs1_data = 32'h1;
    id.rs2 = 5'd6;
    id.rs2_data = 32'h22;
    wb_reg_write = 1'b1;
    wb_rd = 5'd5;
    wb_data = 32'hDEAD;
    step("bypass_full");
    chk("bypass_rs1", 256'(dut.rs1_data), 256'(32'hDEAD));
    chk("bypass_rs2", 256'(dut.rs2_data), 256'(32'h22));

    id.rs2 = 5'd5;
    id.rs2_data = 32'h33;
    wb_data = 32'hBEEF;
    step("bypass_both");
    chk("both_rs2", 256'(dut.rs2_data), 256'(32'hBEEF));

    id = rnd_id();
    id.valid = 1'b1;
    id.rs1 = 5'd2;
    id.rs2 = 5'd7;
    id.rs2_data = 32'h11;
    wb_reg_write = 1'b0;
    exp_v = id;
    step("pre_stall_load");
    stall = 1'b1;
    id = rnd_id();
    step("stall_c1");
    chk("stall_c1_hold", 256'(dut), 256'(exp_v));
    id = rnd_id();
    wb_reg_write = 1'b1;
    wb_rd = 5'd7;
    wb_data = 32'h55;
    exp_v.rs2_data = 32'h55;
    step("stall_c2");
    chk("stall_c2_refresh", 256'(dut), 256'(exp_v));
    wb_reg_write = 1'b0;
    id = rnd_id();
    step("stall_c3");
    chk("stall_c3_hold", 256'(dut), 256'(exp_v));

    stall = 1'b0;
    id = rnd_id();
    id.valid = 1'b1;
    id.rs1 = 5'd0;
    id.rs1_data = 32'h1234;
    wb_reg_write = 1'b1;
    wb_rd = 5'd0;
    wb_data = 32'hFFFF;
    step("x0_full");
    chk("x0_rs1", 256'(dut.rs1_data), 256'(32'h1234));

    stall = 1'b1;
    rst_n = 1'b0;
    wb_reg_write = 1'b0;
    step("rst_mid_stall");
    chk("rst_mid_valid", 256'(dut.valid), 256'(0));
    rst_n = 1'b1;
    stall = 1'b0;
    id = rnd_id();
    id.valid = 1'b1;
    exp_v = id;
    step("post_rst_load");
    chk("post_rst_eq", 256'(dut), 256'(exp_v));

    for (int i = 0; i < 400; i++) begin
      id = rnd_id();
      rst_n = ($urandom_range(0, 39) != 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 2) == 0);
      wb_reg_write = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 3));
      wb_data = $urandom;
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-003 SHALL have port stall, input, 1, hold the current EX contents (load-use or structural stall).
REQ-004 SHALL have port flush, input, 1, insert a bubble (branch/jump redirect).
REQ-005 SHALL have ports id_valid 1, id_pc 32, id_rs1_data 32, id_rs2_data 32, id_imm 32, id_rs1 5, id_rs2 5, id_rd 5, as inputs, the decoded ID-stage payload.
REQ-006 SHALL have control inputs id_alu_op 4, id_alu_src 1, id_mem_read 1, id_mem_write 1, id_reg_write 1, id_mem_to_reg 2, id_branch 1, id_jump 1.
REQ-007 SHALL have ports wb_reg_write 1, wb_rd 5, wb_data 32, as inputs, the write-back port of the register file.
REQ-008 SHALL have outputs ex_valid plus ex_<field> for every REQ-005/006 field, same widths, all registered.
REQ-009 ex_rs1, ex_rs2 and ex_rd SHALL feed the downstream forwarding unit, and ex_rs1_data and ex_rs2_data SHALL feed slot I0 of the EX operand 4:1 muxes.

Function
REQ-010 Priority per cycle SHALL be: reset > flush > stall > load.
REQ-011 Load (no flush, no stall) SHALL copy every id_* field into the matching ex_* register with latency 1 cycle; ex_valid <= id_valid.
REQ-012 A load with id_valid=0 SHALL load a bubble per REQ-014.
REQ-013 Flush SHALL load a bubble regardless of stall.
REQ-014 A bubble SHALL set ex_valid=0, clear all control outputs (reg_write, mem_read, mem_write, branch, jump, alu_src, alu_op, mem_to_reg) to 0, and clear all data/index outputs to 0.
REQ-015 Stall without flush SHALL hold all ex_* outputs except the operand refresh of REQ-017.
REQ-016 Load-time WB bypass: if wb_reg_write=1, wb_rd!=0 and wb_rd==id_rs1, ex_rs1_data SHALL capture wb_data instead of id_rs1_data; the same rule SHALL apply independently to rs2.
REQ-017 Stall-time refresh: while stalled with ex_valid=1, if wb_reg_write=1, wb_rd!=0 and wb_rd==ex_rs1, ex_rs1_data SHALL be updated to wb_data; the same rule SHALL apply independently to rs2; no other field SHALL change.
REQ-018 wb_rd==0 SHALL never trigger a bypass or refresh; x0 operands SHALL pass through unchanged.
REQ-019 rs1==rs2 matching wb_rd SHALL update both operands in the same cycle.
REQ-020 A bubble SHALL NOT be refreshed (ex_valid=0 blocks REQ-017).
REQ-021 No combinational path SHALL exist from any input to any output.

Reset
REQ-022 With rst_n=0 at a rising edge, all outputs SHALL become 0 (bubble state) by the next cycle, overriding flush, stall and load.
REQ-023 A reset asserted mid-stall SHALL discard the held instruction; the first edge after release SHALL perform a normal load.

Structure
REQ-024 A shared package SHALL hold the field widths (XLEN=32, REG_IDX=5, ALU_OP_W=4, MEM_TO_REG_W=2), the ALU op encodings, and the bubble control constant.
REQ-025 One sub-module, opnd_cap, SHALL implement the REQ-016/017/018 capture logic for one operand and SHALL be instantiated twice (rs1, rs2).
REQ-026 Data fields SHALL use ordinary enabled registers, with no clock gating.

Verification
REQ-027 Reset: drive rst_n=0 with id_valid=1 and stall=1 -> next cycle all outputs 0.
REQ-028 Load/latency: id_pc=0x100, id_rs1_data=0xA, id_reg_write=1 -> one cycle later ex_pc=0x100, ex_rs1_data=0xA, ex_valid=1.
REQ-029 Flush+stall same cycle: stall=1, flush=1 -> ex_valid=0, ex_reg_write=0, ex_mem_write=0.
REQ-030 Load bypass: id_rs1=5, id_rs1_data=0x1, wb_reg_write=1, wb_rd=5, wb_data=0xDEAD -> ex_rs1_data=0xDEAD, ex_rs2_data unchanged from id_rs2_data.
REQ-031 Stall refresh: hold ex_rs2=7 under stall for 3 cycles; in cycle 2 drive wb_rd=7, wb_data=0x55 -> ex_rs2_data=0x55 from cycle 3 and all other fields constant throughout.
REQ-032 x0 guard: id_rs1=0, wb_rd=0, wb_reg_write=1, wb_data=0xFFFF -> ex_rs1_data=id_rs1_data.
